// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates NUM_CH partial sums onto a bias, then rounds, shifts, ReLUs and saturates
//
// Purpose: downstream stage of the convolution adder tree. One signed partial
//   sum is taken per accepted beat; NUM_CH beats are summed onto a bias that is
//   sampled with the first beat. The final sum is rounded half-up, arithmetic
//   right-shifted, optionally clamped at zero and saturated to OUT_WIDTH bits.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous abort of the current group
//   in_valid/in_ready/din partial-sum input stream
//   bias, shift, relu_en  per-group settings, sampled on the first beat
//   out_valid/out_ready   output handshake
//   dout                  signed saturated activation
module psum_accumulator #(
  parameter int IN_WIDTH  = 13,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 8,
  parameter int NUM_CH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic [ACC_WIDTH-1:0] bias,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] dout
);

  localparam int CNT_W = $clog2(NUM_CH + 1);
  // Wide enough that the rounding constant (up to 2^30) never wraps.
  localparam int RW = ACC_WIDTH + 32;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

  state_t               state, state_n;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     ch_cnt;
  logic [4:0]           shift_q;
  logic                 relu_q;
  logic [OUT_WIDTH-1:0] dout_q;

  logic                 accept;
  logic                 last_beat;
  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic [4:0]           eff_shift;
  logic                 eff_relu;
  logic signed [RW-1:0] r_ext, rnd, r_sh, r_relu, r_sat;
  logic [OUT_WIDTH-1:0] dout_n;

  assign in_ready  = rst_n && (state != S_OUTPUT);
  assign out_valid = (state == S_OUTPUT);
  assign dout      = dout_q;
  assign din_ext   = {{(ACC_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};

  always_comb begin
    state_n   = state;
    accept    = in_valid && in_ready;
    // In IDLE the incoming beat starts a group, so the live bias/shift/relu
    // apply; that matters when NUM_CH==1 and the first beat is also the last.
    sum       = ((state == S_IDLE) ? bias : acc) + din_ext;
    eff_shift = (state == S_IDLE) ? shift   : shift_q;
    eff_relu  = (state == S_IDLE) ? relu_en : relu_q;
    last_beat = accept && ((state == S_IDLE) ? (NUM_CH == 1)
                                             : (ch_cnt == CNT_W'(NUM_CH - 1)));

    r_ext = {{(RW-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
    rnd   = '0;
    if (eff_shift != 5'd0) rnd = RW'(1) << (eff_shift - 5'd1);
    r_sh   = (r_ext + rnd) >>> eff_shift;
    r_relu = (eff_relu && (r_sh < 0)) ? '0 : r_sh;
    if (r_relu > SAT_MAX)      r_sat = SAT_MAX;
    else if (r_relu < SAT_MIN) r_sat = SAT_MIN;
    else                       r_sat = r_relu;
    dout_n = r_sat[OUT_WIDTH-1:0];

    case (state)
      S_IDLE:   if (accept) state_n = (NUM_CH == 1) ? S_OUTPUT : S_ACCUM;
      S_ACCUM:  if (last_beat) state_n = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (clear) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ch_cnt  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      dout_q  <= '0;
    end else if (clear) begin
      acc    <= '0;
      ch_cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      if (state == S_IDLE) begin
        ch_cnt  <= CNT_W'(1);
        shift_q <= shift;
        relu_q  <= relu_en;
      end else begin
        ch_cnt <= ch_cnt + CNT_W'(1);
      end
      if (last_beat) dout_q <= dout_n;
    end else if (out_valid && out_ready) begin
      ch_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed and randomized scoreboard bench for psum_accumulator
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] din = '0;
  logic [23:0] bias = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  dout;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  psum_accumulator #(.IN_WIDTH(13), .ACC_WIDTH(24), .OUT_WIDTH(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .bias(bias), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input longint sum, input int sh, input bit relu);
    longint r;
    r = sum;
    if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic beat(input int d, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    din = 13'(d);
    check("in_ready_beat", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Drives one 4-beat group; the caller pushes the expected result.
  task automatic run_group(input int b, input int sh, input bit relu,
                           input int d0, input int d1, input int d2, input int d3, input int gap);
    bias = 24'(b);
    shift = 5'(sh);
    relu_en = relu;
    beat(d0, gap);
    beat(d1, gap);
    beat(d2, gap);
    check("not_valid_early", {31'b0, out_valid}, 0);
    beat(d3, gap);
    check("latency_out_valid", {31'b0, out_valid}, 1);
  endtask

  task automatic collect(input string tag);
    int n;
    int exp;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, {31'b0, out_valid}, 1);
    exp = exp_q.pop_front();
    check(tag, $signed(dout), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'b0, out_valid}, 0);
  endtask

  initial begin
    // reset state
    #3;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_dout", $signed(dout), 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {31'b0, in_ready}, 1);

    // 1: basic rounding
    exp_q.push_back(70);
    run_group(10, 2, 0, 100, 200, -50, 20, 0);
    collect("s1_dout");

    // 2: negative saturation and ReLU
    exp_q.push_back(-128);
    run_group(0, 0, 0, -500, -500, -500, -500, 0);
    collect("s2_sat_neg");
    exp_q.push_back(0);
    run_group(0, 0, 1, -500, -500, -500, -500, 1);
    collect("s2_relu");

    // 3: positive saturation and negative rounding
    exp_q.push_back(127);
    run_group(0, 4, 0, 4000, 4000, 4000, 4000, 0);
    collect("s3_sat_pos");
    exp_q.push_back(-1);
    run_group(-6, 2, 0, 0, 0, 0, 0, 0);
    collect("s3_round_neg");

    // 4: backpressure holds output and blocks input
    exp_q.push_back(70);
    run_group(10, 2, 0, 100, 200, -50, 20, 0);
    in_valid = 1'b1;
    din = 13'(7);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s4_in_ready", {31'b0, in_ready}, 0);
      check("s4_out_valid", {31'b0, out_valid}, 1);
      check("s4_dout_stable", $signed(dout), exp_q[0]);
    end
    collect("s4_dout");
    in_valid = 1'b0;
    exp_q.push_back(4);
    run_group(0, 0, 0, 1, 1, 1, 1, 0);
    collect("s4_next_group");

    // 5: clear aborts a group and drops the same-cycle beat
    bias = 24'(0);
    shift = 5'(0);
    beat(1000, 0);
    beat(1000, 0);
    in_valid = 1'b1;
    din = 13'(1000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("s5_after_clear", {31'b0, out_valid}, 0);
    exp_q.push_back(10);
    run_group(0, 0, 0, 1, 2, 3, 4, 0);
    collect("s5_dout");

    // 6: asynchronous reset while output is pending
    exp_q.push_back(70);
    run_group(10, 2, 0, 100, 200, -50, 20, 0);
    void'(exp_q.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_out_valid", {31'b0, out_valid}, 0);
    check("s6_dout", $signed(dout), 0);
    check("s6_in_ready", {31'b0, in_ready}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(70);
    run_group(10, 2, 0, 100, 200, -50, 20, 0);
    collect("s6_fresh");

    // randomized groups with gaps, checked against the reference model
    for (int g = 0; g < 6; g++) begin
      int b, sh, d0, d1, d2, d3;
      bit rl;
      b  = int'($urandom_range(4000)) - 2000;
      sh = int'($urandom_range(8));
      rl = 1'($urandom_range(1));
      d0 = int'($urandom_range(8191)) - 4096;
      d1 = int'($urandom_range(8191)) - 4096;
      d2 = int'($urandom_range(8191)) - 4096;
      d3 = int'($urandom_range(8191)) - 4096;
      exp_q.push_back(model(longint'(b + d0 + d1 + d2 + d3), sh, rl));
      run_group(b, sh, rl, d0, d1, d2, d3, g % 3);
      collect("rand_dout");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
